// File: rtl/burst_mem_responder.sv
// burst_mem_responder
//   Behavioural line memory answering an initiator's line read/write requests
//   with a fixed-latency burst of four 64-bit beats.
//
//   Parameters
//     LATENCY     : edges from acceptance to the first beat (1..255)
//     DEPTH_LINES : number of 256-bit lines, power of two (2..1024)
//
//   Ports
//     clk, rst            : clock, async active-high reset
//     mem_read, mem_write : request strobes, held high until the transfer ends
//     mem_addr            : line address, bits [4:0] ignored, upper bits alias
//     mem_wdata           : write beat, sampled at the edge ending each resp cycle
//     mem_rdata           : registered read beat, valid while mem_resp is high
//     mem_resp            : registered beat strobe, 4 cycles per completed transfer
//     err                 : sticky protocol-violation flag
module burst_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_is_wr;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_lat_cnt;
  logic [1:0]         r_beat;
  logic [63:0]        r_rdata;
  logic               r_resp;
  logic               r_err;

  // Beat-addressed storage: entry {line, beat} so each beat commits on its own.
  logic [63:0]        r_mem [DEPTH_LINES*4];

  logic               w_req_held;
  logic               w_accept;
  logic               w_both;
  logic               w_enter_burst;
  logic               w_beat_adv;
  logic               w_burst_err;
  logic               w_wr_en;
  logic               w_rd_load;
  logic [1:0]         w_rd_beat;
  logic [IDX_W-1:0]   w_idx_in;
  logic               w_unused;

  assign w_idx_in   = mem_addr[5 +: IDX_W];
  assign w_unused   = ^{mem_addr[4:0], mem_addr[31:5+IDX_W]};
  // Only the strobe of the latched operation keeps the transfer alive.
  assign w_req_held = r_is_wr ? mem_write : mem_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_both        = 1'b0;
    w_enter_burst = 1'b0;
    w_beat_adv    = 1'b0;
    w_burst_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_read && mem_write) begin
          w_both = 1'b1;
        end else if (mem_read || mem_write) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req_held) begin
          w_state_nxt = S_IDLE;
        end else if (r_lat_cnt == 8'd0) begin
          w_enter_burst = 1'b1;
          w_state_nxt   = S_BURST;
        end
      end
      S_BURST: begin
        if (!w_req_held) begin
          w_burst_err = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_beat_adv = 1'b1;
          if (r_beat == 2'd3) w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_en   = w_beat_adv && r_is_wr;
  // Prefetch the beat for the next resp cycle so mem_rdata comes from a flop.
  assign w_rd_beat = w_enter_burst ? 2'd0 : r_beat + 2'd1;
  assign w_rd_load = !r_is_wr && (w_enter_burst || (w_beat_adv && r_beat != 2'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr   <= 1'b0;
      r_idx     <= '0;
      r_lat_cnt <= 8'd0;
      r_beat    <= 2'd0;
      r_rdata   <= 64'd0;
      r_resp    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_resp <= (w_state_nxt == S_BURST);
      if (w_both || w_burst_err) r_err <= 1'b1;
      if (w_accept) begin
        r_is_wr   <= mem_write;
        r_idx     <= w_idx_in;
        r_lat_cnt <= 8'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_lat_cnt != 8'd0) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end
      if (w_enter_burst)   r_beat <= 2'd0;
      else if (w_beat_adv) r_beat <= r_beat + 2'd1;
      if (w_rd_load) r_rdata <= r_mem[{r_idx, w_rd_beat}];
    end
  end

  // Storage is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_idx, r_beat}] <= mem_wdata;
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = r_resp;
  assign err       = r_err;

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the number of clock edges from request acceptance to the first data beat; the legal range is 1..255.
REQ-002 The block SHALL have parameter DEPTH_LINES, default 64, meaning the number of 256-bit lines stored; it SHALL be a power of two, 2..1024.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_read, input, 1 bit: the initiator's line-read request, held high until the transfer ends.
REQ-006 The block SHALL have port mem_write, input, 1 bit: the initiator's line-write request, held high until the transfer ends.
REQ-007 The block SHALL have port mem_addr, input, 32 bits: the line address; it is held stable while a request is high, and bits [4:0] are ignored.
REQ-008 The block SHALL have port mem_wdata, input, 64 bits: the write beat, valid in each cycle where mem_resp is high during a write.
REQ-009 The block SHALL have port mem_rdata, output, 64 bits: the read beat, valid in each cycle where mem_resp is high during a read.
REQ-010 The block SHALL have port mem_resp, output, 1 bit: the beat strobe; it is high for exactly 4 consecutive cycles per completed transfer.
REQ-011 The block SHALL have port err, output, 1 bit: a sticky protocol-violation flag.

Function
REQ-012 The line index SHALL be mem_addr[5 +: log2(DEPTH_LINES)]; higher address bits SHALL be ignored, so addresses alias modulo DEPTH_LINES lines.
REQ-013 Beat k (k = 0..3) SHALL map to line bits [64k+63 : 64k], transferred in ascending k with no wrap-around reordering.
REQ-014 The FSM SHALL have four states: IDLE, WAIT, BURST, DONE.
REQ-015 In IDLE, exactly one of mem_read/mem_write high at an edge SHALL latch the operation type and line index, load the latency counter with LATENCY-1, and move to WAIT.
REQ-016 In IDLE, mem_read and mem_write both high at an edge SHALL set err, start no transfer, and leave the FSM in IDLE.
REQ-017 In WAIT, the counter SHALL decrement each edge; at counter 0 the FSM SHALL move to BURST with the beat counter at 0, so the first mem_resp cycle begins LATENCY edges after acceptance.
REQ-018 In WAIT, if the latched request is seen low at an edge, the FSM SHALL abort to IDLE without touching memory or err.
REQ-019 In BURST, mem_resp SHALL be high; mem_resp is a registered output with no combinational path from the inputs.
REQ-020 On a read, mem_rdata SHALL present beat k of the latched line in the k-th mem_resp cycle; it is registered, and its value outside mem_resp cycles is don't-care.
REQ-021 On a write, mem_wdata SHALL be sampled at the edge ending the k-th mem_resp cycle and written into beat k immediately, so beats commit individually.
REQ-022 The beat counter SHALL increment each BURST edge; after beat 3 the FSM SHALL go to DONE and mem_resp SHALL go low.
REQ-023 DONE SHALL last exactly one cycle with mem_resp low and requests ignored, so the initiator can deassert; the FSM then returns to IDLE.
REQ-024 A request still high in IDLE after DONE SHALL be accepted as a new transfer, so back-to-back transfers have at least a LATENCY+1 cycle gap between bursts.
REQ-025 A latched request seen low during BURST SHALL set err and send the FSM to IDLE at that edge; beats already written remain committed.
REQ-026 Once set, err SHALL stay high until rst.
REQ-027 A read of a line SHALL return the most recently written data for that line; a read of a never-written line returns undefined data.

Reset
REQ-028 rst high SHALL immediately force state to IDLE, mem_resp=0, err=0, mem_rdata=0, and both counters to 0, independent of clk.
REQ-029 rst SHALL NOT clear the memory array; contents survive reset.
REQ-030 rst asserted mid-WAIT or mid-BURST SHALL abandon the transfer; beats written before the reset edge remain, and after rst drops the first edge is treated as IDLE.

Verification
REQ-031 Write line 0x00000040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read it -> the first mem_resp comes 4 edges after acceptance, exactly 4 resp cycles each, and the read returns the beats in order.
REQ-032 With DEPTH_LINES=64, write 0x00000020 then read 0x00000820 -> the write data is returned (alias).
REQ-033 mem_read and mem_write asserted together -> no mem_resp, err=1 and sticky through later valid transfers until rst.
REQ-034 mem_read dropped during WAIT -> no mem_resp, err stays 0, and the next request completes normally.
REQ-035 mem_write dropped after 2 resp cycles -> err=1; a read shows beats 0-1 new and beats 2-3 old.
REQ-036 rst pulsed mid-BURST of a read -> mem_resp and err are 0 asynchronously, and a previously written line reads back intact.
